dca_matrix_step_issuer: RTL and testbench



---
 rtl/dca_matrix_step_issuer.sv | 179 +++++++++++++++++
 tb/tb_dca_matrix_step_issuer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_matrix_step_issuer.sv
// -----------------------------------------------------------------------------
// dca_matrix_step_issuer
// Issue controller for the DCA matrix MAC datapath. Takes one blocked-step
// instruction at a time, waits for the MAC and every requested LSU channel,
// issues, and on MAC completion pops the consumed LSU/accumulator entries.
// Outstanding stores are tracked by a credit counter and drained after the
// last step.
//
// Optional feature macro: DCA_STEP_ISSUER_STORE_FENCE_EN
//   defined   -> a NO_CAL+LOAD_ACC readback also waits for all stores to land
//   undefined -> a NO_CAL+LOAD_ACC readback completes on acc_valid alone
// -----------------------------------------------------------------------------
module dca_matrix_step_issuer #(
    parameter  int NUM_LSU               = 3,
    parameter  int MAX_STORE_OUTSTANDING = 3,
    parameter  int MATRIX_NUM_ROW        = 8,
    parameter  int MATRIX_NUM_COL        = 8,
    localparam int BW_OPCODE             = 2 + NUM_LSU,
    localparam int BW_INST               = MATRIX_NUM_ROW + MATRIX_NUM_COL + 1 + BW_OPCODE
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               clear,
    input  logic               enable,
    output logic               busy,
    input  logic               inst_valid,
    input  logic [BW_INST-1:0] inst,
    output logic               inst_ready,
    input  logic [NUM_LSU-1:0] lsu_req_ready,
    output logic [NUM_LSU-1:0] lsu_req_valid,
    output logic [NUM_LSU-1:0] lsu_pop,
    input  logic               mac_ready,
    output logic               mac_issue_valid,
    output logic [BW_INST-1:0] mac_inst,
    input  logic               mac_done,
    input  logic               acc_valid,
    output logic               acc_pop,
    input  logic               store_resp,
    output logic               step_done,
    output logic               all_done
);

    // The highest channel is the store channel; all lower channels are loads.
    localparam int STORE_IDX = NUM_LSU - 1;
    localparam int CNT_W     = $clog2(MAX_STORE_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STORE_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_store_cnt;

    // Instruction field decode: {row_mask, col_mask, last, opcode}.
    logic               w_no_cal;
    logic               w_load_acc;
    logic [NUM_LSU-1:0] w_lsu_req;
    logic               w_last;

    assign w_no_cal   = inst[0];
    assign w_load_acc = inst[1];
    assign w_lsu_req  = inst[BW_OPCODE-1:2];
    assign w_last     = inst[BW_OPCODE];

    // Issue gating: every requested channel ready, and a store credit free
    // whenever the store channel is requested.
    logic w_lsu_ok;
    logic w_store_ok;
    logic w_store_settled;
    logic w_acc_ok;

    assign w_lsu_ok   = &(~w_lsu_req | lsu_req_ready);
    assign w_store_ok = ~w_lsu_req[STORE_IDX] | (r_store_cnt < MAX_CNT);

    // All stores have landed by the end of this cycle.
    assign w_store_settled = (r_store_cnt == '0) | ((r_store_cnt == ONE_CNT) & store_resp);

`ifdef DCA_STEP_ISSUER_STORE_FENCE_EN
    assign w_acc_ok = acc_valid & w_store_settled;
`else
    assign w_acc_ok = acc_valid;
`endif

    assign busy      = (r_state != ST_IDLE);
    assign mac_inst  = inst;
    assign step_done = inst_ready;

    // State register; reset and clear both return to IDLE.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and single-cycle handshake pulses.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next    = r_state;
        inst_ready      = 1'b0;
        mac_issue_valid = 1'b0;
        lsu_req_valid   = '0;
        lsu_pop         = '0;
        acc_pop         = 1'b0;
        all_done        = 1'b0;

        if (clear) begin
            w_state_next = ST_IDLE;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (inst_valid) begin
                        if (w_no_cal) begin
                            // Readback-only or discard: completes without the MAC.
                            if (!w_load_acc || w_acc_ok) begin
                                inst_ready = 1'b1;
                                lsu_pop    = w_lsu_req;
                                acc_pop    = w_load_acc;
                            end
                        end else if (mac_ready && w_lsu_ok && w_store_ok) begin
                            mac_issue_valid = 1'b1;
                            lsu_req_valid   = w_lsu_req;
                            w_state_next    = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mac_done) begin
                        inst_ready   = 1'b1;
                        lsu_pop      = w_lsu_req;
                        acc_pop      = w_load_acc;
                        w_state_next = w_last ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (w_store_settled) begin
                        all_done     = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Store credit counter: +1 when a store slot is popped, -1 per store
    // response; both together hold. A response with nothing in flight is
    // ignored. Keeps counting while the FSM is frozen or cleared.
    logic w_store_inc;
    logic w_store_dec;

    assign w_store_inc = lsu_pop[STORE_IDX];
    assign w_store_dec = store_resp & (r_store_cnt != '0);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_store_cnt <= '0;
        end else begin
            case ({w_store_inc, w_store_dec})
                2'b10:   r_store_cnt <= r_store_cnt + ONE_CNT;
                2'b01:   r_store_cnt <= r_store_cnt - ONE_CNT;
                default: r_store_cnt <= r_store_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dca_matrix_step_issuer.sv
// -----------------------------------------------------------------------------
// tb_dca_matrix_step_issuer
// Directed, table-driven bench for dca_matrix_step_issuer (NUM_LSU=3, MAX=3).
// Each vector is one clock cycle: inputs driven after the falling edge,
// outputs sampled shortly afterwards, before the next rising edge.
// Follows DCA_STEP_ISSUER_STORE_FENCE_EN for the fenced readback case.
// -----------------------------------------------------------------------------
module tb_dca_matrix_step_issuer;

    localparam int NL  = 3;
    localparam int MX  = 3;
    localparam int NR  = 8;
    localparam int NC  = 8;
    localparam int BWI = NR + NC + 1 + 2 + NL;

`ifdef DCA_STEP_ISSUER_STORE_FENCE_EN
    localparam bit FENCE = 1'b1;
`else
    localparam bit FENCE = 1'b0;
`endif

    logic           clk;
    logic           rstnn;
    logic           clear;
    logic           enable;
    logic           busy;
    logic           inst_valid;
    logic [BWI-1:0] inst;
    logic           inst_ready;
    logic [NL-1:0]  lsu_req_ready;
    logic [NL-1:0]  lsu_req_valid;
    logic [NL-1:0]  lsu_pop;
    logic           mac_ready;
    logic           mac_issue_valid;
    logic [BWI-1:0] mac_inst;
    logic           mac_done;
    logic           acc_valid;
    logic           acc_pop;
    logic           store_resp;
    logic           step_done;
    logic           all_done;

    dca_matrix_step_issuer #(
        .NUM_LSU               (NL),
        .MAX_STORE_OUTSTANDING (MX),
        .MATRIX_NUM_ROW        (NR),
        .MATRIX_NUM_COL        (NC)
    ) dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .clear           (clear),
        .enable          (enable),
        .busy            (busy),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_ready      (inst_ready),
        .lsu_req_ready   (lsu_req_ready),
        .lsu_req_valid   (lsu_req_valid),
        .lsu_pop         (lsu_pop),
        .mac_ready       (mac_ready),
        .mac_issue_valid (mac_issue_valid),
        .mac_inst        (mac_inst),
        .mac_done        (mac_done),
        .acc_valid       (acc_valid),
        .acc_pop         (acc_pop),
        .store_resp      (store_resp),
        .step_done       (step_done),
        .all_done        (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed handshake word: {busy, inst_ready, step_done, mac_issue_valid,
    // lsu_req_valid[2:0], lsu_pop[2:0], acc_pop, all_done}.
    logic [11:0] act;
    assign act = {busy, inst_ready, step_done, mac_issue_valid,
                  lsu_req_valid, lsu_pop, acc_pop, all_done};

    typedef struct {
        logic           clr;
        logic           en;
        logic           iv;
        logic [BWI-1:0] in;
        logic [NL-1:0]  rdy;
        logic           mr;
        logic           md;
        logic           av;
        logic           sr;
        logic [11:0]    exp;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [BWI-1:0] mk(input logic last, input logic [2:0] req,
                                          input logic lacc, input logic nocal);
        return {8'hA5, 8'h3C, last, req, lacc, nocal};
    endfunction

    function automatic logic [11:0] e(input logic bz, input logic ir, input logic iss,
                                      input logic [2:0] rv, input logic [2:0] pop,
                                      input logic ap, input logic ad);
        return {bz, ir, ir, iss, rv, pop, ap, ad};
    endfunction

    function automatic vec_t v(input logic clr, input logic en, input logic iv,
                               input logic [BWI-1:0] in, input logic [2:0] rdy,
                               input logic mr, input logic md, input logic av,
                               input logic sr, input logic [11:0] ex);
        vec_t t;
        t.clr = clr; t.en = en; t.iv = iv; t.in = in; t.rdy = rdy;
        t.mr = mr; t.md = md; t.av = av; t.sr = sr; t.exp = ex;
        return t;
    endfunction

    // One cycle: drive, settle, compare.
    task automatic run(input vec_t t, input string nm);
        @(negedge clk);
        clear         = t.clr;
        enable        = t.en;
        inst_valid    = t.iv;
        inst          = t.in;
        lsu_req_ready = t.rdy;
        mac_ready     = t.mr;
        mac_done      = t.md;
        acc_valid     = t.av;
        store_resp    = t.sr;
        #2;
        checks++;
        if (act !== t.exp) begin
            failures++;
            $display("FAIL %s: outputs got %b expected %b", nm, act, t.exp);
        end
        if (t.exp[8]) begin
            checks++;
            if (mac_inst !== t.in) begin
                failures++;
                $display("FAIL %s mac_inst: got %h expected %h", nm, mac_inst, t.in);
            end
        end
    endtask

    task automatic check_word(input logic [11:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: outputs got %b expected %b", nm, act, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [BWI-1:0] i_a, i_s, i_l, i_n, i_na;
        logic [11:0]    e0, eb, e_iss_a, e_cmp_a, e_iss_s, e_cmp_s, e_iss_l, e_cmp_l, e_ad, e_rb;

        i_a  = mk(1'b0, 3'b011, 1'b0, 1'b0);
        i_s  = mk(1'b0, 3'b100, 1'b0, 1'b0);
        i_l  = mk(1'b1, 3'b001, 1'b0, 1'b0);
        i_n  = mk(1'b0, 3'b000, 1'b0, 1'b1);
        i_na = mk(1'b0, 3'b000, 1'b1, 1'b1);

        e0      = e(0, 0, 0, 3'b000, 3'b000, 0, 0);
        eb      = e(1, 0, 0, 3'b000, 3'b000, 0, 0);
        e_iss_a = e(0, 0, 1, 3'b011, 3'b000, 0, 0);
        e_cmp_a = e(1, 1, 0, 3'b000, 3'b011, 0, 0);
        e_iss_s = e(0, 0, 1, 3'b100, 3'b000, 0, 0);
        e_cmp_s = e(1, 1, 0, 3'b000, 3'b100, 0, 0);
        e_iss_l = e(0, 0, 1, 3'b001, 3'b000, 0, 0);
        e_cmp_l = e(1, 1, 0, 3'b000, 3'b001, 0, 0);
        e_ad    = e(1, 0, 0, 3'b000, 3'b000, 0, 1);
        e_rb    = e(0, 1, 0, 3'b000, 3'b000, 1, 0);

        // Basic step, enable/mac_ready gating.
        tbl.push_back(v(0, 1, 1, i_a,  3'b011, 1, 0, 0, 0, e_iss_a));
        tbl.push_back(v(0, 1, 1, i_a,  3'b111, 1, 1, 0, 0, e_cmp_a));
        tbl.push_back(v(0, 1, 0, '0,   3'b111, 1, 0, 0, 0, e0));
        tbl.push_back(v(0, 0, 1, i_a,  3'b111, 1, 0, 0, 0, e0));
        tbl.push_back(v(0, 1, 1, i_a,  3'b111, 0, 0, 0, 0, e0));
        tbl.push_back(v(0, 1, 1, i_a,  3'b111, 1, 0, 0, 0, e_iss_a));
        tbl.push_back(v(0, 1, 1, i_a,  3'b111, 1, 0, 0, 0, eb));
        tbl.push_back(v(0, 0, 1, i_a,  3'b111, 1, 1, 0, 0, eb));
        tbl.push_back(v(0, 1, 1, i_a,  3'b111, 1, 1, 0, 0, e_cmp_a));
        // Three stores fill the credits; the fourth is held off.
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(v(0, 1, 1, i_s, 3'b111, 1, 0, 0, 0, e_iss_s));
            tbl.push_back(v(0, 1, 1, i_s, 3'b111, 1, 1, 0, 0, e_cmp_s));
        end
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 0, 0, 0, e0));
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 0, 0, 0, e0));
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 0, 0, 1, e0));
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 0, 0, 0, e_iss_s));
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 1, 0, 1, e_cmp_s));
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 0, 0, 0, e_iss_s));
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 1, 0, 0, e_cmp_s));
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 0, 0, 0, e0));
        // Release one credit, then last step drains two outstanding stores.
        tbl.push_back(v(0, 1, 0, '0,   3'b111, 1, 0, 0, 1, e0));
        tbl.push_back(v(0, 1, 1, i_l,  3'b111, 1, 0, 0, 0, e_iss_l));
        tbl.push_back(v(0, 1, 1, i_l,  3'b111, 1, 1, 0, 0, e_cmp_l));
        tbl.push_back(v(0, 1, 0, '0,   3'b111, 1, 0, 0, 0, eb));
        tbl.push_back(v(0, 1, 0, '0,   3'b111, 1, 0, 0, 1, eb));
        tbl.push_back(v(0, 1, 0, '0,   3'b111, 1, 0, 0, 1, e_ad));
        tbl.push_back(v(0, 1, 0, '0,   3'b111, 1, 0, 0, 0, e0));
        // NO_CAL discard and accumulator readback.
        tbl.push_back(v(0, 1, 1, i_n,  3'b111, 1, 0, 0, 0, e(0, 1, 0, 3'b000, 3'b000, 0, 0)));
        tbl.push_back(v(0, 1, 1, i_na, 3'b111, 1, 0, 0, 0, e0));
        tbl.push_back(v(0, 1, 1, i_na, 3'b111, 1, 0, 1, 0, e_rb));
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 0, 0, 0, e_iss_s));
        tbl.push_back(v(0, 1, 1, i_s,  3'b111, 1, 1, 0, 0, e_cmp_s));
        tbl.push_back(v(0, 1, 1, i_na, 3'b111, 1, 0, 1, 0, FENCE ? e0 : e_rb));
        tbl.push_back(v(0, 1, 1, i_na, 3'b111, 1, 0, 1, 1, e_rb));
        // Last step with nothing outstanding; DRAIN frozen while enable is low.
        tbl.push_back(v(0, 1, 1, i_l,  3'b111, 1, 0, 0, 0, e_iss_l));
        tbl.push_back(v(0, 1, 1, i_l,  3'b111, 1, 1, 0, 0, e_cmp_l));
        tbl.push_back(v(0, 0, 0, '0,   3'b111, 1, 0, 0, 0, eb));
        tbl.push_back(v(0, 1, 0, '0,   3'b111, 1, 0, 0, 0, e_ad));
        tbl.push_back(v(0, 1, 0, '0,   3'b111, 1, 0, 0, 0, e0));

        // Reset state.
        rstnn = 1'b0; clear = 1'b0; enable = 1'b0; inst_valid = 1'b0; inst = '0;
        lsu_req_ready = '0; mac_ready = 1'b0; mac_done = 1'b0; acc_valid = 1'b0;
        store_resp = 1'b0;
        #12;
        check_word(e0, "reset_outputs");
        checks++;
        if (mac_inst !== '0) begin
            failures++;
            $display("FAIL reset_mac_inst: got %h expected 0", mac_inst);
        end
        @(negedge clk);
        rstnn = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            run(tbl[k], $sformatf("vec%0d", k));
        end

        // Channel 1 stalled for five cycles, then the step issues at once.
        for (int k = 0; k < 5; k++) begin
            run(v(0, 1, 1, i_a, 3'b101, 1, 0, 0, 0, e0), $sformatf("stall%0d", k));
        end
        run(v(0, 1, 1, i_a, 3'b111, 1, 0, 0, 0, e_iss_a), "stall_issue");
        run(v(0, 1, 1, i_a, 3'b111, 1, 1, 0, 0, e_cmp_a), "stall_done");

        // Clear in BUSY with two stores outstanding: no pops, count kept.
        for (int k = 0; k < 2; k++) begin
            run(v(0, 1, 1, i_s, 3'b111, 1, 0, 0, 0, e_iss_s), "clr_st_iss");
            run(v(0, 1, 1, i_s, 3'b111, 1, 1, 0, 0, e_cmp_s), "clr_st_cmp");
        end
        run(v(0, 1, 1, i_a, 3'b111, 1, 0, 0, 0, e_iss_a), "clr_issue");
        run(v(1, 1, 1, i_a, 3'b111, 1, 1, 0, 0, eb),      "clr_cycle");
        run(v(0, 1, 0, '0,  3'b111, 1, 0, 0, 0, e0),      "clr_idle");
        run(v(0, 1, 1, i_l, 3'b111, 1, 0, 0, 0, e_iss_l), "clr_last_iss");
        run(v(0, 1, 1, i_l, 3'b111, 1, 1, 0, 0, e_cmp_l), "clr_last_cmp");
        run(v(0, 1, 0, '0,  3'b111, 1, 0, 0, 1, eb),      "clr_drain1");
        run(v(0, 1, 0, '0,  3'b111, 1, 0, 0, 1, e_ad),    "clr_drain2");
        run(v(0, 1, 0, '0,  3'b111, 1, 0, 0, 0, e0),      "clr_after");

        // Reset mid-step with one store counted: counter must return to 0.
        run(v(0, 1, 1, i_s, 3'b111, 1, 0, 0, 0, e_iss_s), "rst_st_iss");
        run(v(0, 1, 1, i_s, 3'b111, 1, 1, 0, 0, e_cmp_s), "rst_st_cmp");
        run(v(0, 1, 1, i_s, 3'b111, 1, 0, 0, 0, e_iss_s), "rst_iss");
        @(negedge clk);
        mac_done   = 1'b1;
        inst_valid = 1'b0;
        inst       = '0;
        #1 rstnn = 1'b0;
        #1 check_word(e0, "rst_async");
        @(negedge clk);
        #1 check_word(e0, "rst_held");
        mac_done = 1'b0;
        rstnn    = 1'b1;
        run(v(0, 1, 1, i_l, 3'b111, 1, 0, 0, 0, e_iss_l), "rst_last_iss");
        run(v(0, 1, 1, i_l, 3'b111, 1, 1, 0, 0, e_cmp_l), "rst_last_cmp");
        run(v(0, 1, 0, '0,  3'b111, 1, 0, 0, 0, e_ad),    "rst_drain");
        run(v(0, 1, 0, '0,  3'b111, 1, 0, 0, 0, e0),      "rst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
